// File: rtl/fifo_rr_drain_sched_if.sv
// Bus bundle between the round-robin drain scheduler, its fifo bank and the
// downstream consumer. master = scheduler side, slave = fifos/consumer side.
interface fifo_rr_drain_sched_if #(
    parameter int DATA_WIDTH = 128,
    parameter int N_QUEUES   = 4
);
    localparam int QW = (N_QUEUES > 1) ? $clog2(N_QUEUES) : 1;

    logic [N_QUEUES-1:0]            fifo_mty;
    logic [N_QUEUES-1:0]            fifo_almost_full;
    logic [N_QUEUES*DATA_WIDTH-1:0] fifo_q;
    logic [N_QUEUES-1:0]            fifo_rd;
    logic                           out_valid;
    logic                           out_ready;
    logic [DATA_WIDTH-1:0]          out_data;
    logic [QW-1:0]                  out_qid;
    logic                           busy;

    modport master (
        input  fifo_mty, fifo_almost_full, fifo_q, out_ready,
        output fifo_rd, out_valid, out_data, out_qid, busy
    );

    modport slave (
        output fifo_mty, fifo_almost_full, fifo_q, out_ready,
        input  fifo_rd, out_valid, out_data, out_qid, busy
    );
endinterface

// File: rtl/fifo_rr_drain_sched.sv
// Round-robin drain of N fifos into one valid/ready stream, with optional
// almost_full priority and a 2-entry skid absorbing the fifo read latency.
module fifo_rr_drain_sched #(
    parameter int DATA_WIDTH = 128,
    parameter int N_QUEUES   = 4,
    parameter int BURST_MAX  = 4,
    parameter int PRIO_AF    = 1
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   srst,
    fifo_rr_drain_sched_if.master  bus
);
    localparam int QW = (N_QUEUES > 1) ? $clog2(N_QUEUES) : 1;
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [QW-1:0] LAST_Q    = QW'(N_QUEUES - 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [QW-1:0] grant_reg, grant_next;
    logic [QW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [BW-1:0] burst_cnt_reg, burst_cnt_next;

    logic [DATA_WIDTH-1:0] skid_data_reg [2];
    logic [QW-1:0]         skid_qid_reg  [2];
    logic                  wr_ptr_reg, rd_ptr_reg;
    logic [1:0]            count_reg;

    logic [N_QUEUES-1:0] eligible, af_eligible, grant_onehot, rd_vec;
    logic [QW-1:0]       rr_win, af_win, win, grant_inc;
    logic                any_elig, any_af, grant_mty, grant_af;
    logic                preempt, rd_ok, push, pop;

    assign eligible    = ~bus.fifo_mty;
    assign af_eligible = eligible & bus.fifo_almost_full;

    // Scan from rr_ptr upward with wrap; lowest offset wins.
    always_comb begin : pick_winner
        int idx;
        idx      = 0;
        rr_win   = '0;
        af_win   = '0;
        any_elig = 1'b0;
        any_af   = 1'b0;
        for (int k = N_QUEUES - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= N_QUEUES) idx = idx - N_QUEUES;
            if (eligible[idx]) begin
                rr_win   = QW'(idx);
                any_elig = 1'b1;
            end
            if (af_eligible[idx]) begin
                af_win = QW'(idx);
                any_af = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_QUEUES; gi++) begin : g_onehot
            assign grant_onehot[gi] = (grant_reg == QW'(gi));
        end
    endgenerate

    assign win       = ((PRIO_AF != 0) && any_af) ? af_win : rr_win;
    assign grant_mty = |(bus.fifo_mty & grant_onehot);
    assign grant_af  = |(bus.fifo_almost_full & grant_onehot);
    assign grant_inc = (grant_reg == LAST_Q) ? '0 : grant_reg + 1'b1;
    assign preempt   = (PRIO_AF != 0) && (|(af_eligible & ~grant_onehot)) && !grant_af;

    assign pop  = (count_reg != 2'd0) && bus.out_ready;
    assign push = (state_reg == WAIT);
    // Only read when the skid is sure to have room for the word next cycle.
    assign rd_ok  = (state_reg == READ) && !grant_mty && ((count_reg - {1'b0, pop}) <= 2'd1);
    assign rd_vec = rd_ok ? grant_onehot : '0;

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        rr_ptr_next    = rr_ptr_reg;
        burst_cnt_next = burst_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (any_elig) begin
                    grant_next     = win;
                    burst_cnt_next = '0;
                    state_next     = READ;
                end
            end
            READ: begin
                if (rd_ok) begin
                    burst_cnt_next = burst_cnt_reg + 1'b1;
                    state_next     = WAIT;
                end else if (grant_mty) begin
                    rr_ptr_next = grant_inc;
                    state_next  = IDLE;
                end
            end
            WAIT: begin
                if ((burst_cnt_reg < BURST_LIM) && !grant_mty && !preempt) begin
                    state_next = READ;
                end else begin
                    rr_ptr_next = grant_inc;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            count_reg     <= 2'd0;
        end else if (srst) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            count_reg     <= 2'd0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            rr_ptr_reg    <= rr_ptr_next;
            burst_cnt_reg <= burst_cnt_next;
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    // Skid entries are cleared on reset so out_data/out_qid read back zero.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_skid
            always_ff @(posedge clk or posedge arst) begin
                if (arst) begin
                    skid_data_reg[gi] <= '0;
                    skid_qid_reg[gi]  <= '0;
                end else if (srst) begin
                    skid_data_reg[gi] <= '0;
                    skid_qid_reg[gi]  <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    skid_data_reg[gi] <= bus.fifo_q[int'(grant_reg)*DATA_WIDTH +: DATA_WIDTH];
                    skid_qid_reg[gi]  <= grant_reg;
                end
            end
        end
    endgenerate

    assign bus.fifo_rd   = rd_vec;
    assign bus.out_valid = (count_reg != 2'd0);
    assign bus.out_data  = skid_data_reg[rd_ptr_reg];
    assign bus.out_qid   = skid_qid_reg[rd_ptr_reg];
    assign bus.busy      = (state_reg != IDLE) || (count_reg != 2'd0);
endmodule

// File: tb/tb_fifo_rr_drain_sched.sv
// Directed bench: two schedulers (PRIO_AF=1 as d=0, PRIO_AF=0 as d=1) each drain
// their own model fifo bank, fed identical load/ready/almost_full stimulus.
module tb_fifo_rr_drain_sched;
    localparam int DW = 128;
    localparam int NQ = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          arst = 1'b0;
    logic          srst = 1'b0;
    logic          out_ready = 1'b1;
    logic [NQ-1:0] af = '0;

    fifo_rr_drain_sched_if #(.DATA_WIDTH(DW), .N_QUEUES(NQ)) dif [2] ();

    fifo_rr_drain_sched #(.DATA_WIDTH(DW), .N_QUEUES(NQ), .BURST_MAX(4), .PRIO_AF(1)) u_dut_af (
        .clk(clk), .arst(arst), .srst(srst), .bus(dif[0])
    );
    fifo_rr_drain_sched #(.DATA_WIDTH(DW), .N_QUEUES(NQ), .BURST_MAX(4), .PRIO_AF(0)) u_dut_rr (
        .clk(clk), .arst(arst), .srst(srst), .bus(dif[1])
    );

    int            fill [NQ];
    int            taken [2][NQ];
    int            rdcnt [2][NQ];
    logic [DW-1:0] q_reg [2][NQ];
    logic [NQ-1:0] rd_w [2];
    logic [NQ-1:0] mty_w [2];
    logic          ov [2];
    logic          bz [2];
    logic [DW-1:0] od [2];
    logic [1:0]    oq [2];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int            d;
        int            qid;
        logic [DW-1:0] data;
        int            cyc;
    } rec_t;
    rec_t recs [$];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bus
            assign dif[gi].fifo_mty         = mty_w[gi];
            assign dif[gi].fifo_almost_full = af;
            assign dif[gi].fifo_q           = {q_reg[gi][3], q_reg[gi][2], q_reg[gi][1], q_reg[gi][0]};
            assign dif[gi].out_ready        = out_ready;
            assign rd_w[gi] = dif[gi].fifo_rd;
            assign ov[gi]   = dif[gi].out_valid;
            assign bz[gi]   = dif[gi].busy;
            assign od[gi]   = dif[gi].out_data;
            assign oq[gi]   = dif[gi].out_qid;
        end
    endgenerate

    function automatic logic [DW-1:0] mkword(int q, int idx);
        return {32'hC0DE0000 | 32'(q), 32'(idx) * 32'h9E3779B1, 32'(q), 32'(idx)};
    endfunction

    // Model fifo: registered q, empty flag derived from registered read count.
    always_comb begin
        for (int d = 0; d < 2; d++)
            for (int q = 0; q < NQ; q++)
                mty_w[d][q] = (taken[d][q] >= fill[q]);
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            for (int q = 0; q < NQ; q++)
                if (rd_w[d][q]) begin
                    q_reg[d][q] <= mkword(q, taken[d][q]);
                    taken[d][q] <= taken[d][q] + 1;
                end
    end

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rd_w[d] != '0) begin
                n_assert++;
                if (((rd_w[d] & mty_w[d]) != '0) || !$onehot(rd_w[d])) begin
                    n_fail++;
                    $display("FAIL rd_guard d=%0d cyc=%0d: fifo_rd=%b mty=%b, required one-hot to non-empty", d, cyc, rd_w[d], mty_w[d]);
                end
                for (int q = 0; q < NQ; q++) rdcnt[d][q] += int'(rd_w[d][q]);
            end
            if (ov[d] && out_ready) recs.push_back('{d: d, qid: int'(oq[d]), data: od[d], cyc: cyc});
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int nrec(int d, int base);
        int c = 0;
        for (int i = base; i < recs.size(); i++) if (recs[i].d == d) c++;
        return c;
    endfunction

    function automatic int recidx(int d, int base, int k);
        int c = 0;
        for (int i = base; i < recs.size(); i++)
            if (recs[i].d == d) begin
                if (c == k) return i;
                c++;
            end
        return -1;
    endfunction

    task automatic wait_recs(int base, int n, int maxc, string name);
        int c = 0;
        while ((nrec(0, base) < n || nrec(1, base) < n) && c < maxc) begin
            tick(1);
            c++;
        end
        n_assert++;
        if (nrec(0, base) < n || nrec(1, base) < n) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d/%0d words, required %0d", name, nrec(0, base), nrec(1, base), n);
        end
    endtask

    task automatic check_zero(string name);
        for (int d = 0; d < 2; d++) begin
            n_assert++;
            if (rd_w[d] !== '0 || ov[d] !== 1'b0 || bz[d] !== 1'b0 || oq[d] !== 2'd0 || od[d] !== '0) begin
                n_fail++;
                $display("FAIL %s d=%0d: rd=%b valid=%b busy=%b qid=%0d data=%h, required all zero", name, d, rd_w[d], ov[d], bz[d], oq[d], od[d]);
            end
        end
    endtask

    task automatic do_srst();
        srst = 1'b1;
        tick(1);
        srst = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        #1;
        check_zero("reset_async");
        tick(3);
        check_zero("reset_hold");
        arst = 1'b0;
        tick(1);
        check_zero("reset_release");
    endtask

    task automatic test_idle_empty();
        do_srst();
        for (int c = 0; c < 20; c++) begin
            tick(1);
            for (int d = 0; d < 2; d++) begin
                n_assert++;
                if (rd_w[d] !== '0 || ov[d] !== 1'b0 || bz[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_empty d=%0d c=%0d: rd=%b valid=%b busy=%b, required 0/0/0", d, c, rd_w[d], ov[d], bz[d]);
                end
            end
        end
    endtask

    task automatic test_rr_burst();
        int exp_q [24] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0,0, 1,1, 2,2, 3,3};
        int base, i, j;
        int nxt [2][NQ];
        do_srst();
        out_ready = 1'b1;
        base = recs.size();
        for (int d = 0; d < 2; d++) for (int q = 0; q < NQ; q++) nxt[d][q] = taken[d][q];
        for (int q = 0; q < NQ; q++) fill[q] += 6;
        wait_recs(base, 24, 300, "rr_burst");
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 24; k++) begin
                i = recidx(d, base, k);
                if (i < 0) break;
                n_assert++;
                if (recs[i].qid != exp_q[k] || recs[i].data !== mkword(exp_q[k], nxt[d][exp_q[k]])) begin
                    n_fail++;
                    $display("FAIL rr_order d=%0d k=%0d: qid=%0d data=%h, required qid=%0d data=%h", d, k, recs[i].qid, recs[i].data, exp_q[k], mkword(exp_q[k], nxt[d][exp_q[k]]));
                end
                nxt[d][exp_q[k]]++;
                if (k > 0 && exp_q[k] == exp_q[k-1]) begin
                    j = recidx(d, base, k - 1);
                    n_assert++;
                    if (recs[i].cyc - recs[j].cyc != 2) begin
                        n_fail++;
                        $display("FAIL rr_rate d=%0d k=%0d: spacing=%0d cycles, required 2", d, k, recs[i].cyc - recs[j].cyc);
                    end
                end
            end
        tick(10);
    endtask

    task automatic test_backpressure();
        int base, i;
        int r0 [2];
        int t0 [2];
        logic [DW-1:0] held [2];
        do_srst();
        out_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            r0[d] = rdcnt[d][0];
            t0[d] = taken[d][0];
        end
        fill[0] += 5;
        tick(10);
        for (int d = 0; d < 2; d++) held[d] = od[d];
        tick(10);
        for (int d = 0; d < 2; d++) begin
            n_assert++;
            if (rdcnt[d][0] - r0[d] != 2) begin
                n_fail++;
                $display("FAIL bp_rd_count d=%0d: rd pulses=%0d, required 2", d, rdcnt[d][0] - r0[d]);
            end
            n_assert++;
            if (ov[d] !== 1'b1 || bz[d] !== 1'b1 || od[d] !== mkword(0, t0[d]) || od[d] !== held[d]) begin
                n_fail++;
                $display("FAIL bp_hold d=%0d: valid=%b busy=%b data=%h, required 1/1 data=%h", d, ov[d], bz[d], od[d], mkword(0, t0[d]));
            end
        end
        base = recs.size();
        out_ready = 1'b1;
        wait_recs(base, 5, 100, "bp_release");
        tick(10);
        for (int d = 0; d < 2; d++) begin
            n_assert++;
            if (nrec(d, base) != 5) begin
                n_fail++;
                $display("FAIL bp_count d=%0d: words=%0d, required 5", d, nrec(d, base));
            end
            for (int k = 0; k < 5; k++) begin
                i = recidx(d, base, k);
                if (i < 0) break;
                n_assert++;
                if (recs[i].qid != 0 || recs[i].data !== mkword(0, t0[d] + k)) begin
                    n_fail++;
                    $display("FAIL bp_data d=%0d k=%0d: qid=%0d data=%h, required qid=0 data=%h", d, k, recs[i].qid, recs[i].data, mkword(0, t0[d] + k));
                end
            end
        end
    endtask

    task automatic test_preempt();
        int exp_q [2][12] = '{'{0,0,2,2,2,2,0,0,0,0,0,0}, '{0,0,0,0,2,2,2,2,0,0,0,0}};
        int base, i, seen, c;
        do_srst();
        out_ready = 1'b1;
        af = '0;
        base = recs.size();
        fill[0] += 8;
        fill[2] += 4;
        seen = 0;
        c = 0;
        while (seen < 2 && c < 50) begin
            tick(1);
            if (rd_w[0][0]) seen++;
            c++;
        end
        af[2] = 1'b1;
        wait_recs(base, 12, 300, "preempt");
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 12; k++) begin
                i = recidx(d, base, k);
                if (i < 0) break;
                n_assert++;
                if (recs[i].qid != exp_q[d][k]) begin
                    n_fail++;
                    $display("FAIL preempt_order d=%0d k=%0d: qid=%0d, required %0d", d, k, recs[i].qid, exp_q[d][k]);
                end
            end
        af = '0;
        tick(10);
    endtask

    task automatic test_single_word();
        int base, i;
        int r0 [2][NQ];
        do_srst();
        out_ready = 1'b1;
        base = recs.size();
        for (int d = 0; d < 2; d++) for (int q = 0; q < NQ; q++) r0[d][q] = rdcnt[d][q];
        fill[1] += 1;
        tick(15);
        for (int d = 0; d < 2; d++) begin
            n_assert++;
            if (rdcnt[d][1] - r0[d][1] != 1 || rdcnt[d][0] != r0[d][0] || rdcnt[d][2] != r0[d][2] || rdcnt[d][3] != r0[d][3]) begin
                n_fail++;
                $display("FAIL single_rd d=%0d: q1 pulses=%0d, required exactly 1 and none elsewhere", d, rdcnt[d][1] - r0[d][1]);
            end
            i = recidx(d, base, 0);
            n_assert++;
            if (nrec(d, base) != 1 || i < 0 || recs[i].qid != 1 || bz[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL single_out d=%0d: words=%0d busy=%b, required 1 word from q1, busy 0", d, nrec(d, base), bz[d]);
            end
        end
        base = recs.size();
        fill[0] += 1;
        fill[2] += 1;
        wait_recs(base, 2, 50, "single_rr");
        for (int d = 0; d < 2; d++) begin
            i = recidx(d, base, 0);
            n_assert++;
            if (i < 0 || recs[i].qid != 2) begin
                n_fail++;
                $display("FAIL single_rr_ptr d=%0d: first qid=%0d, required 2", d, (i < 0) ? -1 : recs[i].qid);
            end
        end
        tick(5);
    endtask

    task automatic test_reset_mid();
        int base, i, c;
        int t0 [2];
        do_srst();
        out_ready = 1'b1;
        fill[1] += 1;
        tick(10);
        fill[3] += 4;
        c = 0;
        while (!rd_w[0][3] && c < 30) begin
            tick(1);
            c++;
        end
        tick(1);
        arst = 1'b1;
        #1;
        check_zero("arst_wait_async");
        tick(1);
        check_zero("arst_wait_edge");
        arst = 1'b0;
        base = recs.size();
        fill[1] += 2;
        wait_recs(base, 5, 200, "arst_resume");
        tick(10);
        for (int d = 0; d < 2; d++) begin
            i = recidx(d, base, 0);
            n_assert++;
            if (i < 0 || recs[i].qid != 1 || nrec(d, base) != 5) begin
                n_fail++;
                $display("FAIL arst_rr_ptr d=%0d: first qid=%0d words=%0d, required qid 1, 5 words", d, (i < 0) ? -1 : recs[i].qid, nrec(d, base));
            end
        end
        out_ready = 1'b0;
        for (int d = 0; d < 2; d++) t0[d] = taken[d][0];
        fill[0] += 4;
        tick(12);
        srst = 1'b1;
        tick(1);
        check_zero("srst_read");
        srst = 1'b0;
        base = recs.size();
        out_ready = 1'b1;
        wait_recs(base, 2, 100, "srst_resume");
        tick(10);
        for (int d = 0; d < 2; d++) begin
            n_assert++;
            if (nrec(d, base) != 2) begin
                n_fail++;
                $display("FAIL srst_count d=%0d: words=%0d, required 2", d, nrec(d, base));
            end
            for (int k = 0; k < 2; k++) begin
                i = recidx(d, base, k);
                if (i < 0) break;
                n_assert++;
                if (recs[i].data !== mkword(0, t0[d] + 2 + k)) begin
                    n_fail++;
                    $display("FAIL srst_data d=%0d k=%0d: data=%h, required %h", d, k, recs[i].data, mkword(0, t0[d] + 2 + k));
                end
            end
        end
    endtask

    initial begin
        for (int q = 0; q < NQ; q++) fill[q] = 0;
        test_reset();
        test_idle_empty();
        test_rr_burst();
        test_backpressure();
        test_preempt();
        test_single_word();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
